// File: rtl/cic_ctrl_pkg.sv
// Shared types and defaults for the CIC interpolator sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_t;

    localparam int ISZ_DEF           = 16;
    localparam int RATIO_W_DEF       = 8;
    localparam int CLR_CYCLES_DEF    = 4;
    localparam int DRAIN_SAMPLES_DEF = 4;   // NUM_STAGES + 1 for a 3-stage CIC
    localparam int UCNT_W_DEF        = 16;

    // Ratios below this cannot produce a strobe gap, so they are clamped up.
    localparam int MIN_RATIO = 2;

    function automatic int clamp_ratio(input int req);
        return (req < MIN_RATIO) ? MIN_RATIO : req;
    endfunction

endpackage

// File: rtl/cic_rate_gen.sv
// Phase counter for the input-rate strobe: counts 0..period-1 and wraps.
// Latency: wrap is combinational from the registered phase.
// Backpressure: none; counts freely whenever count_en is high.
module cic_rate_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         count_en,
    input  logic [W-1:0] period,
    output logic         wrap
);

    logic [W-1:0] phase;

    // wrap marks the first cycle of each period while counting
    assign wrap = count_en && (phase == '0);

    // Phase register: cleared when idle so each run starts at phase 0
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            phase <= '0;
        end else if (count_en) begin
            phase <= (phase == period - W'(1)) ? '0 : phase + W'(1);
        end
    end

endmodule

// File: rtl/cic_interp_ctrl.sv
// Sequencer for the 3-stage CIC interpolator: clear, input-rate strobe, drain.
// Latency: accepted sample reaches cic_in with its strobe 1 cycle after s_ready.
// Backpressure: s_ready only on strobe slots; a missed slot still strobes (see CIC_CTRL_UNDERFLOW_HOLD_EN).
module cic_interp_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int ISZ           = ISZ_DEF,
    parameter int RATIO_W       = RATIO_W_DEF,
    parameter int CLR_CYCLES    = CLR_CYCLES_DEF,
    parameter int DRAIN_SAMPLES = DRAIN_SAMPLES_DEF,
    parameter int UCNT_W        = UCNT_W_DEF
) (
    input  logic               out_clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [RATIO_W-1:0] ratio,
    input  logic [ISZ-1:0]     s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               cic_reset,
    output logic               cic_in_clk,
    output logic [ISZ-1:0]     cic_in,
    output logic               running,
    output logic [UCNT_W-1:0]  underflow_cnt
);

    localparam int CLR_W = $clog2(CLR_CYCLES) + 1;
    localparam int DRN_W = $clog2(DRAIN_SAMPLES) + 1;

    ctrl_state_t        state;
    ctrl_state_t        state_nxt;
    logic [RATIO_W-1:0] r_q;
    logic [CLR_W-1:0]   clr_cnt;
    logic [DRN_W-1:0]   drn_cnt;
    logic               counting;
    logic               slot;
    logic               start;
    logic               take;
    logic               miss;
    logic [ISZ-1:0]     fill_data;

    assign counting = (state == ST_RUN) || (state == ST_DRAIN);
    assign start    = (state == ST_IDLE) && enable;
    assign take     = s_ready && s_valid;
    assign miss     = s_ready && !s_valid;

    cic_rate_gen #(
        .W(RATIO_W)
    ) u_rate_gen (
        .clk      (out_clk),
        .reset    (reset),
        .clear    (!counting),
        .count_en (counting),
        .period   (r_q),
        .wrap     (slot)
    );

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        cic_reset = 1'b0;
        running   = 1'b0;
        case (state)
            ST_IDLE: begin
                cic_reset = 1'b1;
                if (enable) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                cic_reset = 1'b1;
                if (!enable) state_nxt = ST_IDLE;
                else if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                running = 1'b1;
                s_ready = slot;
                if (!enable) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // leave only after the last zero strobe has been issued
                if (drn_cnt == DRN_W'(DRAIN_SAMPLES)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge out_clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Ratio latch on start; CLEAR length and DRAIN strobe counters
    always_ff @(posedge out_clk) begin
        if (reset) begin
            r_q     <= RATIO_W'(MIN_RATIO);
            clr_cnt <= '0;
            drn_cnt <= '0;
        end else begin
            if (start) r_q <= RATIO_W'(clamp_ratio(int'(ratio)));
            clr_cnt <= (state == ST_CLEAR) ? clr_cnt + CLR_W'(1) : '0;
            drn_cnt <= (state == ST_DRAIN) ? drn_cnt + DRN_W'(slot) : '0;
        end
    end

`ifdef CIC_CTRL_UNDERFLOW_HOLD_EN
    logic [ISZ-1:0] last_q;

    // Remember the last accepted sample so a missed slot can repeat it
    always_ff @(posedge out_clk) begin
        if (reset || start) last_q <= '0;
        else if (take)      last_q <= s_data;
    end

    assign fill_data = last_q;
`else
    assign fill_data = '0;
`endif

    // Strobe and sample to the interpolator, one cycle after each slot
    always_ff @(posedge out_clk) begin
        if (reset) begin
            cic_in_clk <= 1'b0;
            cic_in     <= '0;
        end else begin
            cic_in_clk <= slot;
            if (slot) begin
                if (take)                 cic_in <= s_data;
                else if (state == ST_RUN) cic_in <= fill_data;
                else                      cic_in <= '0;
            end
        end
    end

    // Saturating count of RUN slots with no sample available
    always_ff @(posedge out_clk) begin
        if (reset || start) begin
            underflow_cnt <= '0;
        end else if (miss && (underflow_cnt != '1)) begin
            underflow_cnt <= underflow_cnt + UCNT_W'(1);
        end
    end

endmodule
